// File: rtl/arm_decode_pkg.sv
// Shared class codes, branch-kind codes and the decoded-record layout for the ARM decode queue.
package arm_decode_pkg;

  localparam logic [2:0] DP_IMM = 3'd0;
  localparam logic [2:0] DP_REG = 3'd1;
  localparam logic [2:0] DP_RSR = 3'd2;
  localparam logic [2:0] MUL    = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] BRANCH = 3'd5;
  localparam logic [2:0] BLOCK  = 3'd6;
  localparam logic [2:0] UNDEF  = 3'd7;

  localparam logic [1:0] JMP_B  = 2'b01;
  localparam logic [1:0] JMP_BL = 2'b10;

  localparam int unsigned COND_W   = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned DP_OP_W  = 4;
  localparam int unsigned IMM_W    = 24;
  localparam int unsigned MEM_OP_W = 2;
  localparam int unsigned JMP_OP_W = 2;
  localparam int unsigned TYPE_W   = 3;
  localparam int unsigned REC_W    = COND_W + 2 * REG_W + DP_OP_W + IMM_W + MEM_OP_W + JMP_OP_W
                                     + TYPE_W;

  typedef struct packed {
    logic [COND_W-1:0]   cond;
    logic [REG_W-1:0]    rn;
    logic [REG_W-1:0]    rd;
    logic [DP_OP_W-1:0]  dp_op;
    logic [IMM_W-1:0]    imm;
    logic [MEM_OP_W-1:0] mem_op;
    logic [JMP_OP_W-1:0] jmp_op;
    logic [TYPE_W-1:0]   itype;
  } dec_rec_t;

endpackage

// File: rtl/arm_instr_classify.sv
// Combinational ARM instruction classifier: raw word -> class and per-class op fields.
module arm_instr_classify
  import arm_decode_pkg::*;
(
  input  logic [31:0]         instr_i,
  output logic [TYPE_W-1:0]   type_o,
  output logic [DP_OP_W-1:0]  dp_op_o,
  output logic [MEM_OP_W-1:0] mem_op_o,
  output logic [JMP_OP_W-1:0] jmp_op_o
);

  // Condition, register and low immediate bits are carried by the record, not decoded here.
  logic unused_bits;
  assign unused_bits = ^{instr_i[31:28], instr_i[19:8], instr_i[3:0]};

  always_comb begin
    type_o   = UNDEF;
    dp_op_o  = '0;
    mem_op_o = '0;
    jmp_op_o = '0;
    unique case (instr_i[27:26])
      2'b00: begin
        if (instr_i[25]) begin
          type_o = DP_IMM;
        end else if (instr_i[7:4] == 4'b1001) begin
          type_o = MUL;
        end else if (instr_i[4]) begin
          type_o = DP_RSR;
        end else begin
          type_o = DP_REG;
        end
        if (type_o != MUL) begin
          dp_op_o = instr_i[24:21];
        end
      end
      2'b01: begin
        type_o   = MEM;
        mem_op_o = {instr_i[25], instr_i[20]};
      end
      2'b10: begin
        if (instr_i[25]) begin
          type_o   = BRANCH;
          jmp_op_o = instr_i[24] ? JMP_BL : JMP_B;
        end else begin
          type_o = BLOCK;
        end
      end
      default: type_o = UNDEF;
    endcase
  end

endmodule

// File: rtl/arm_decode_queue.sv
// Buffered ARM decode stage: classify on enqueue, FIFO of decoded records, per-class pop counters.
module arm_decode_queue
  import arm_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_type,
  output logic [3:0]               out_dp_op,
  output logic [1:0]               out_mem_op,
  output logic [1:0]               out_jmp_op,
  output logic [3:0]               out_cond,
  output logic [3:0]               out_rn,
  output logic [3:0]               out_rd,
  output logic [23:0]              out_imm,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [2:0]               stat_sel,
  output logic [CNT_W-1:0]         stat_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  dec_rec_t          mem_q [DEPTH];
  dec_rec_t          mem_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  stat_q [8];
  logic [CNT_W-1:0]  stat_d [8];

  dec_rec_t          in_rec;
  dec_rec_t          head;
  logic              push, pop;

  arm_instr_classify u_classify (
    .instr_i  (in_instr),
    .type_o   (in_rec.itype),
    .dp_op_o  (in_rec.dp_op),
    .mem_op_o (in_rec.mem_op),
    .jmp_op_o (in_rec.jmp_op)
  );

  assign in_rec.cond = in_instr[31:28];
  assign in_rec.rn   = in_instr[19:16];
  assign in_rec.rd   = in_instr[15:12];
  assign in_rec.imm  = in_instr[23:0];

  // A pop never frees a slot for a push in the same cycle when full.
  assign in_ready  = RST_N & ~flush & (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_q];
  assign count     = count_q;
  assign stat_cnt  = stat_q[stat_sel];

  // Data fields read zero whenever the queue is empty.
  always_comb begin
    out_type   = '0;
    out_dp_op  = '0;
    out_mem_op = '0;
    out_jmp_op = '0;
    out_cond   = '0;
    out_rn     = '0;
    out_rd     = '0;
    out_imm    = '0;
    if (out_valid) begin
      out_type   = head.itype;
      out_dp_op  = head.dp_op;
      out_mem_op = head.mem_op;
      out_jmp_op = head.jmp_op;
      out_cond   = head.cond;
      out_rn     = head.rn;
      out_rd     = head.rd;
      out_imm    = head.imm;
    end
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = in_rec;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Stats count every pop, including one that coincides with a flush.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      stat_d[i] = stat_q[i];
      if (pop && (head.itype == i[2:0]) && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < 8; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      for (int i = 0; i < 8; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule
